// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait with timeout halt.
// Optional stall-cycle counter is built only when HAZARD_STALL_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        idExMemRead,
  input  logic [4:0]  idExRt,
  input  logic [4:0]  ifIdRs,
  input  logic [4:0]  ifIdRt,
  input  logic        branchTaken,
  input  logic        dmemReq,
  input  logic        dmemReady,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        idExWrite,
  output logic        exMemWrite,
  output logic        memWbWrite,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] stallCnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HALT = 2'b10,
    ST_ILL  = 2'b11
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_r, state_nxt_s;
  logic [7:0] wait_cnt_r, wait_cnt_nxt_s;
  logic       halted_r, halted_nxt_s;
  logic       d_stall_s, load_use_s;
  logic       pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s;
  logic       ifid_fl_s, idex_fl_s;

  assign d_stall_s  = dmemReq & ~dmemReady;
  assign load_use_s = idExMemRead & (idExRt != 5'd0) &
                      ((idExRt == ifIdRs) | (idExRt == ifIdRt));

  // State, wait counter and sticky halt flag
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= 8'd0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      halted_r   <= halted_nxt_s;
    end
  end

  // Next-state and Mealy enable/flush decode
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    halted_nxt_s   = halted_r;
    pc_we_s        = 1'b1;
    ifid_we_s      = 1'b1;
    idex_we_s      = 1'b1;
    exmem_we_s     = 1'b1;
    memwb_we_s     = 1'b1;
    ifid_fl_s      = 1'b0;
    idex_fl_s      = 1'b0;
    case (state_r)
      ST_RUN, ST_WAIT: begin
        if ((state_r == ST_RUN && d_stall_s) || (state_r == ST_WAIT && !dmemReady)) begin
          {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s} = 5'b00000;
          if (state_r == ST_RUN) begin
            state_nxt_s    = ST_WAIT;
            wait_cnt_nxt_s = 8'd1;
          end else if (wait_cnt_r == TIMEOUT_C) begin
            state_nxt_s  = ST_HALT;
            halted_nxt_s = 1'b1;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
          end
        end else begin
          // Release cycle out of a wait resolves hazards exactly like RUN
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = 8'd0;
          if (branchTaken) begin
            ifid_fl_s = 1'b1;
            idex_fl_s = 1'b1;
          end else if (load_use_s) begin
            pc_we_s   = 1'b0;
            ifid_we_s = 1'b0;
            idex_fl_s = 1'b1;
          end else begin
            pc_we_s   = 1'b1;
          end
        end
      end
      ST_HALT: begin
        {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s} = 5'b00000;
      end
      default: begin
        {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s} = 5'b00000;
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  assign pcWrite    = nRst & pc_we_s;
  assign ifIdWrite  = nRst & ifid_we_s;
  assign idExWrite  = nRst & idex_we_s;
  assign exMemWrite = nRst & exmem_we_s;
  assign memWbWrite = nRst & memwb_we_s;
  assign ifIdFlush  = nRst & ifid_fl_s;
  assign idExFlush  = nRst & idex_fl_s;
  assign halted     = halted_r;
  assign state      = state_r;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      stall_cnt_r <= 32'd0;
    end else if (!pcWrite && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stallCnt = stall_cnt_r;
`else
  assign stallCnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (TIMEOUT = 4): rule-level model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        idExMemRead = 1'b0;
  logic [4:0]  idExRt = 5'd0, ifIdRs = 5'd0, ifIdRt = 5'd0;
  logic        branchTaken = 1'b0, dmemReq = 1'b0, dmemReady = 1'b0;
  logic        pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite;
  logic        ifIdFlush, idExFlush, halted;
  logic [1:0]  state;
  logic [31:0] stallCnt;

  pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .nRst(nRst), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .branchTaken(branchTaken),
    .dmemReq(dmemReq), .dmemReady(dmemReady), .pcWrite(pcWrite),
    .ifIdWrite(ifIdWrite), .idExWrite(idExWrite), .exMemWrite(exMemWrite),
    .memWbWrite(memWbWrite), .ifIdFlush(ifIdFlush), .idExFlush(idExFlush),
    .halted(halted), .state(state), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = running, 1 = waiting on memory, 2 = halted
  int          m_mode = 0;
  int          m_wait = 0;
  bit          m_halted = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  int c_checks = 0, c_pass = 0, s_checks = 0, s_pass = 0;

  function automatic logic [7:0] model_outs();
    bit dstall, lu, frozen;
    dstall = dmemReq && !dmemReady;
    lu = idExMemRead && (idExRt != 5'd0) && (idExRt == ifIdRs || idExRt == ifIdRt);
    frozen = (m_mode == 2) || (m_mode == 0 && dstall) || (m_mode == 1 && !dmemReady);
    if (!nRst)       return 8'b0000_0000;
    if (frozen)      return {7'b0000000, m_halted};
    if (branchTaken) return {7'b1111111, m_halted};
    if (lu)          return {7'b0011101, m_halted};
    return {7'b1111100, m_halted};
  endfunction

  function automatic logic [7:0] dut_outs();
    return {pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite, ifIdFlush, idExFlush, halted};
  endfunction

  // Model state advances on the same edge as the design; reset is asynchronous
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_mode <= 0; m_wait <= 0; m_halted <= 1'b0; m_cnt <= 32'd0;
    end else begin
`ifdef HAZARD_STALL_CNT_EN
      if (model_outs()[7] == 1'b0 && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
`endif
      if (m_mode == 0 && dmemReq && !dmemReady) begin
        m_mode <= 1; m_wait <= 1;
      end else if (m_mode == 1 && dmemReady) begin
        m_mode <= 0; m_wait <= 0;
      end else if (m_mode == 1 && m_wait == TO) begin
        m_mode <= 2; m_halted <= 1'b1;
      end else if (m_mode == 1) begin
        m_wait <= m_wait + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    c_checks = c_checks + 3;
    if (dut_outs() === model_outs()) c_pass = c_pass + 1;
    else $display("FAIL model_outs: got %b expected %b (t=%0t)", dut_outs(), model_outs(), $time);
    if (state === 2'(m_mode)) c_pass = c_pass + 1;
    else $display("FAIL model_state: got %0d expected %0d (t=%0t)", state, m_mode, $time);
    if (stallCnt === m_cnt) c_pass = c_pass + 1;
    else $display("FAIL model_stallCnt: got %0d expected %0d (t=%0t)", stallCnt, m_cnt, $time);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    s_checks = s_checks + 1;
    if (act === exp) s_pass = s_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input logic rst_v, input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                     input logic [4:0] irt, input logic br, input logic req, input logic rdy);
    @(posedge clk);
    #1;
    nRst = rst_v; idExMemRead = mr; idExRt = rt; ifIdRs = rs; ifIdRt = irt;
    branchTaken = br; dmemReq = req; dmemReady = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] exp_cnt1;

  initial begin
`ifdef HAZARD_STALL_CNT_EN
    exp_cnt1 = 32'd1;
`else
    exp_cnt1 = 32'd0;
`endif
    // Reset held
    cyc(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'(dut_outs()), 32'h00);
    chk("rst_cnt", stallCnt, 32'd0);
    idle();
    chk("idle_outs", 32'(dut_outs()), 32'hF8);

    // Load-use via Rs: single bubble
    cyc(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("lu_outs", 32'(dut_outs()), 32'h3A);
    idle();
    chk("lu_after_outs", 32'(dut_outs()), 32'hF8);
    chk("lu_cnt", stallCnt, exp_cnt1);
    cyc(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("lu_rt_outs", 32'(dut_outs()), 32'h3A);
    // Zero register and non-load never stall
    cyc(1'b1, 1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("zero_outs", 32'(dut_outs()), 32'hF8);
    cyc(1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    // Branch beats load-use
    cyc(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("br_lu_outs", 32'(dut_outs()), 32'hFE);

    // Memory wait: three low cycles then ready (branch ignored while stalling)
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("dw_a_state", 32'(state), 32'd0);
    chk("dw_a_outs", 32'(dut_outs()), 32'h00);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("dw_b_state", 32'(state), 32'd1);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("dw_c_outs", 32'(dut_outs()), 32'h00);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("dw_rel_state", 32'(state), 32'd1);
    chk("dw_rel_outs", 32'(dut_outs()), 32'hF8);
    idle();
    chk("dw_after_state", 32'(state), 32'd0);

    // Release cycle with a load-use hazard
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("rel_lu_outs", 32'(dut_outs()), 32'h3A);
    idle();

    // Ready arrives in the same cycle the count reaches TIMEOUT
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("race_outs", 32'(dut_outs()), 32'hF8);
    idle();
    chk("race_state", 32'(state), 32'd0);

    // Timeout to HALT
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TO; i++) cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("to_last_wait_state", 32'(state), 32'd1);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("to_state", 32'(state), 32'd2);
    chk("to_outs", 32'(dut_outs()), 32'h01);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    chk("halt_ready_state", 32'(state), 32'd2);
    chk("halt_ready_outs", 32'(dut_outs()), 32'h01);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_halted", 32'(halted), 32'd0);
    idle();
    chk("post_halt_outs", 32'(dut_outs()), 32'hF8);

    // Reset during a wait abandons it
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("wait_rst_state", 32'(state), 32'd0);
    chk("wait_rst_outs", 32'(dut_outs()), 32'hF8);
    idle();

    $display("%0d/%0d checks passed", c_pass + s_pass, c_checks + s_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16 (legal 1..255), is the number of cycles in DMEM_WAIT with dmemReady low before HALT.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 nRst  in  1  asynchronous, active-low reset.
REQ-004 idExMemRead  in  1  ID/EX instruction is a load.
REQ-005 idExRt  in  5  ID/EX load destination register.
REQ-006 ifIdRs, ifIdRt  in  5 each  IF/ID source registers.
REQ-007 branchTaken  in  1  EX stage resolved a taken branch/jump.
REQ-008 dmemReq  in  1  MEM stage has a data-memory access outstanding.
REQ-009 dmemReady  in  1  data memory completes the access this cycle.
REQ-010 pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite  out  1 each  stage register enables.
REQ-011 ifIdFlush, idExFlush  out  1 each  bubble insertion into IF/ID and ID/EX.
REQ-012 halted  out  1  sticky memory-timeout indicator.
REQ-013 state  out  2  current FSM state: RUN=00, DMEM_WAIT=01, HALT=10.
REQ-014 stallCnt  out  32  stall-cycle count (see Configuration).

Function
REQ-015 Outputs are Mealy: combinational from state and current inputs; defaults are all enables 1 and flushes 0.
REQ-016 dStall = dmemReq & !dmemReady; loadUse = idExMemRead & (idExRt!=0) & ((idExRt==ifIdRs) | (idExRt==ifIdRt)).
REQ-017 RUN priority 1: if dStall, all five enables = 0 and flushes = 0 (full freeze); next state DMEM_WAIT; waitCnt loads 1.
REQ-018 RUN priority 2: else if branchTaken, ifIdFlush = 1, idExFlush = 1, pcWrite = 1; loadUse is ignored; state remains RUN.
REQ-019 RUN priority 3: else if loadUse, pcWrite = 0, ifIdWrite = 0, idExFlush = 1 (exactly one bubble per detection); state remains RUN.
REQ-020 DMEM_WAIT with dmemReady = 0: full freeze as REQ-017; waitCnt increments.
REQ-021 DMEM_WAIT with dmemReady = 0 and waitCnt == TIMEOUT: next state HALT; halted is set on that edge.
REQ-022 DMEM_WAIT with dmemReady = 1 (release cycle): outputs evaluated as RUN priorities 2-3 with dStall treated as 0; next state RUN; waitCnt clears.
REQ-023 If dmemReady and waitCnt == TIMEOUT occur in the same cycle, dmemReady wins and the next state is RUN.
REQ-024 HALT: all enables 0, flushes 0, halted = 1; the block leaves HALT only through reset.
REQ-025 waitCnt is 8 bits and cannot wrap, because TIMEOUT is at most 255.
REQ-026 Encoding 11 is illegal; if reached, the next state is RUN.

Reset
REQ-027 nRst low asynchronously forces state = RUN, waitCnt = 0, halted = 0 and stallCnt = 0.
REQ-028 While nRst is low, all enables = 0 and flushes = 0.
REQ-029 Reset during DMEM_WAIT or HALT abandons the wait; the first cycle after release is RUN.

Configuration
REQ-030 With macro HAZARD_STALL_CNT_EN defined, stallCnt increments on every cycle with pcWrite == 0 outside reset and saturates at 0xFFFFFFFF.
REQ-031 Without HAZARD_STALL_CNT_EN, the counter is not built and stallCnt is tied to 0.

Verification
REQ-032 Load-use: idExMemRead = 1, idExRt = 5, ifIdRs = 5 for one cycle -> pcWrite = 0, ifIdWrite = 0, idExFlush = 1 that cycle only; stallCnt += 1 (macro on).
REQ-033 Zero register: idExMemRead = 1, idExRt = 0, ifIdRt = 0 -> no stall; all enables = 1.
REQ-034 Branch plus load-use in the same cycle -> ifIdFlush = 1, idExFlush = 1, pcWrite = 1; no stall.
REQ-035 Data-memory wait: dmemReq = 1, dmemReady low for 3 cycles, then high -> state 01 for 3 cycles, full freeze for 3 cycles, release cycle enables = 1, then state 00.
REQ-036 Timeout with TIMEOUT = 4: dmemReady held low -> state = 10 and halted = 1 after 4 wait cycles; a later dmemReady = 1 has no effect; nRst pulse -> state 00, halted = 0.
REQ-037 Macro off: run REQ-035 -> stallCnt stays 0.
